// File: rtl/dct2_pkg.sv
// Shared constants, cosine table and helpers for the VVC DCT-II datapath.
package dct2_pkg;

    localparam int SAMPLE_W = 9;
    localparam int COEF_W   = 16;
    localparam int LANES    = 32;

    typedef enum logic [1:0] {DCT4, DCT8, DCT16, DCT32} dct_size_e;

    // First quadrant of the scaled cosine, indexed in 1/128ths of a period.
    localparam logic signed [7:0] DCT_T [0:32] = '{
        8'sd64, 8'sd90, 8'sd90, 8'sd90, 8'sd89, 8'sd88, 8'sd87, 8'sd85,
        8'sd83, 8'sd82, 8'sd80, 8'sd78, 8'sd75, 8'sd73, 8'sd70, 8'sd67,
        8'sd64, 8'sd61, 8'sd57, 8'sd54, 8'sd50, 8'sd46, 8'sd43, 8'sd38,
        8'sd36, 8'sd31, 8'sd25, 8'sd22, 8'sd18, 8'sd13, 8'sd9,  8'sd4,
        8'sd0
    };

    function automatic logic signed [7:0] dct_f(input logic [6:0] m);
        int mi;
        logic signed [7:0] r;
        mi = int'(m);
        if (mi <= 32)      r = DCT_T[mi];
        else if (mi <= 64) r = -DCT_T[64 - mi];
        else if (mi <= 96) r = -DCT_T[mi - 64];
        else               r = DCT_T[128 - mi];
        return r;
    endfunction

    function automatic logic [2:0] shift_of(input dct_size_e n);
        logic [2:0] s;
        case (n)
            DCT4:    s = 3'd1;
            DCT8:    s = 3'd2;
            DCT16:   s = 3'd3;
            default: s = 3'd4;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dct2_1d_if.sv
// Sample/size input and coefficient output bundle of the 1-D DCT.
interface dct2_1d_if;
    import dct2_pkg::*;

    logic [1:0]                 N;
    logic [LANES*SAMPLE_W-1:0]  X_test;
    logic [LANES*COEF_W-1:0]    Y;

    modport master (output N, output X_test, input Y);
    modport slave  (input N, input X_test, output Y);

endinterface

// File: rtl/dct2_row_mac.sv
// One output lane: dot product of matrix row k with the samples, round, shift, clamp.
module dct2_row_mac
    import dct2_pkg::*;
(
    input  logic [4:0]                       k,
    input  logic [1:0]                       n,
    input  logic [LANES-1:0][SAMPLE_W-1:0]   x,
    output logic signed [COEF_W-1:0]         y
);
    localparam int ACC_W = 24;

    logic signed [ACC_W-1:0] acc, prod, half, rnd;
    logic [5:0]              npts;
    logic [6:0]              kl;
    logic [6:0]              m;
    logic [2:0]              s;
    logic signed [7:0]       c;

    always_comb begin
        npts = 6'd4 << n;
        s    = shift_of(dct_size_e'(n));
        // Row k of the N-point matrix is row k*L of the 32-point one.
        kl   = {2'b00, k} << (2'd3 - n);
        acc  = '0;
        prod = '0;
        m    = '0;
        c    = '0;
        for (int i = 0; i < LANES; i++) begin
            m    = 7'(int'(kl) * (2 * i + 1));
            c    = dct_f(m);
            prod = ACC_W'(c) * ACC_W'($signed(x[i]));
            if (6'(i) < npts) acc = acc + prod;
        end
        half = ACC_W'(1) << (s - 3'd1);
        rnd  = acc + half;
        rnd  = rnd >>> s;
        if ({1'b0, k} >= npts)       y = '0;
        else if (rnd > 24'sd32767)   y = 16'sh7fff;
        else if (rnd < -24'sd32768)  y = 16'sh8000;
        else                         y = rnd[COEF_W-1:0];
    end

endmodule

// File: rtl/dct2_1d.sv
// 1-D forward DCT-II, size 4/8/16/32: 32 combinational lanes into one output register.
module dct2_1d
    import dct2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    dct2_1d_if.slave   bus
);
    logic [LANES-1:0][SAMPLE_W-1:0] x;
    logic [LANES-1:0][COEF_W-1:0]   y_c;

    assign x = bus.X_test;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dct2_row_mac u_mac (
            .k (5'(g)),
            .n (bus.N),
            .x (x),
            .y (y_c[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) bus.Y <= '0;
        else     bus.Y <= y_c;
    end

endmodule

// File: tb/tb_dct2_1d.sv
// Directed and random vectors for dct2_1d against hand values and an independent model.
module tb_dct2_1d;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    dct2_1d_if bus ();

    dct2_1d dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int tb_t [33] = '{64,90,90,90,89,88,87,85,83,82,80,78,75,73,70,67,
                      64,61,57,54,50,46,43,38,36,31,25,22,18,13,9,4,0};

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int coef(input int k, input int n, input int sz);
        int m, v;
        m = (k * (32 / sz) * (2 * n + 1)) % 128;
        if (m > 64) m = 128 - m;
        if (m > 32) v = -tb_t[64 - m];
        else        v = tb_t[m];
        return v;
    endfunction

    function automatic logic [511:0] model(input logic [1:0] nc, input logic [287:0] x);
        logic [511:0]      r;
        logic signed [8:0] smp;
        int sz, sh, acc, v;
        r  = '0;
        sz = 4 << nc;
        sh = int'(nc) + 1;
        for (int k = 0; k < sz; k++) begin
            acc = 0;
            for (int n = 0; n < sz; n++) begin
                smp = x[9*n +: 9];
                acc += coef(k, n, sz) * int'(smp);
            end
            v = (acc + (1 << (sh - 1))) >>> sh;
            if (v > 32767)  v = 32767;
            if (v < -32768) v = -32768;
            r[16*k +: 16] = 16'(v);
        end
        return r;
    endfunction

    task automatic apply(input logic r, input logic [1:0] nc, input logic [287:0] x);
        @(negedge clk);
        rst        = r;
        bus.N      = nc;
        bus.X_test = x;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [287:0] rnd_vec();
        logic [287:0] x;
        for (int j = 0; j < 32; j++) x[9*j +: 9] = 9'($urandom);
        return x;
    endfunction

    function automatic logic [287:0] fill(input logic [8:0] v);
        logic [287:0] x;
        for (int j = 0; j < 32; j++) x[9*j +: 9] = v;
        return x;
    endfunction

    initial begin
        logic [287:0] x;
        logic [511:0] exp;
        logic [1:0]   nc;

        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 2'($urandom), rnd_vec());
            chk("reset_hold", bus.Y, '0);
        end

        // 4-point impulse right after reset release
        x = '0; x[8:0] = 9'd1;
        apply(1'b0, 2'd0, x);
        exp = '0;
        exp[15:0] = 16'd32; exp[31:16] = 16'd42; exp[47:32] = 16'd32; exp[63:48] = 16'd18;
        chk("imp4", bus.Y, exp);

        apply(1'b0, 2'd3, fill(9'd1));
        exp = '0; exp[15:0] = 16'd128;
        chk("dc32", bus.Y, exp);

        apply(1'b0, 2'd3, fill(9'h100));
        exp = '0; exp[15:0] = 16'h8000;
        chk("neg32", bus.Y, exp);

        apply(1'b0, 2'd3, fill(9'd255));
        exp = '0; exp[15:0] = 16'd32640;
        chk("pos32", bus.Y, exp);

        x = rnd_vec(); x[71:0] = '0;
        apply(1'b0, 2'd1, x);
        chk("mask8", bus.Y, '0);

        x = rnd_vec(); x[143:0] = '0;
        apply(1'b0, 2'd2, x);
        chk("mask16", bus.Y, '0);

        for (int i = 0; i < 1000; i++) begin
            x  = rnd_vec();
            nc = 2'($urandom);
            if (i == 500) begin
                apply(1'b1, nc, x);
                chk("rst_mid", bus.Y, '0);
            end else begin
                apply(1'b0, nc, x);
                chk("rand", bus.Y, model(nc, x));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dct2_1d.md
# dct2_1d

Single-stage 1-D forward DCT-II using VVC integer transform matrices, selectable size 4/8/16/32 points. It is the first (column) pass of the 2-D `dct2_2d` transform. It takes a packed vector of signed residual samples and produces a packed vector of scaled, rounded transform coefficients, registered on one clock.

## Interface
- No parameters. Fixed widths: 9-bit signed samples, 16-bit signed coefficients, 32 lanes.
- `clk` input, 1 bit: the single clock. All state changes on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `N` input, 2 bits: transform size. 0 selects 4 points, 1 selects 8, 2 selects 16, 3 selects 32.
- `X_test` input, 288 bits: 32 signed 9-bit samples. Sample n occupies `X_test[9n+8:9n]`; sample 0 is in the least-significant bits.
- `Y` output, 512 bits: 32 signed 16-bit coefficients. Coefficient k occupies `Y[16k+15:16k]`.

## Operation
- Size and shift: L = 32/N_pts. The shift is S = log2(N_pts) − 1, so S is 1, 2, 3, 4 for sizes 4, 8, 16, 32.
- Cosine table T[0..32]: 64,90,90,90,89,88,87,85,83,82,80,78,75,73,70,67,64,61,57,54,50,46,43,38,36,31,25,22,18,13,9,4,0.
- Define f(m), with m taken mod 128:
  - T[m] for m ≤ 32
  - −T[64−m] for 32 < m ≤ 64
  - −T[m−64] for 64 < m ≤ 96
  - T[128−m] for m > 96
- The 32-point matrix entry is c32[k][n] = f(k·(2n+1)), except row 0, which is 64 for every n.
- The N-point matrix is cN[k][n] = c32[k·L][n], for k, n < N_pts.
- For k < N_pts: acc_k = Σ_{n<N_pts} cN[k][n]·x_n. The accumulator is signed and at least 21 bits wide.
- y_k = (acc_k + 2^(S−1)) >>> S, using an arithmetic shift (floor toward −∞).
- y_k is saturated to [−32768, 32767]. This bound cannot be exceeded for 9-bit inputs, but the clamp is required anyway.
- Lanes k ≥ N_pts output 0.
- Input samples n ≥ N_pts are ignored. They may hold any value.
- Fully combinational datapath from `X_test`/`N` to a single output register stage.

## Timing
- `X_test` and `N` are sampled on the rising edge of `clk`. `Y` reflects that sample from the same edge onward: latency 1 cycle, throughput 1 vector per cycle.
- No handshake. A new vector is accepted every cycle.
- `N` may change on any cycle. Each output uses the `N` captured with its own data.
- Reset: when `rst` is 1 at a rising edge, `Y` becomes 0 at that edge, overriding the input.
  - Reset mid-stream discards the in-flight vector.
  - The first cycle after `rst` deasserts captures normally.
- After reset `Y` is 0. `Y` is never X after the first reset edge.

## Structure
- Shared package `dct2_pkg` holds:
  - the T table as a localparam array
  - the f(m) function
  - lane widths (`SAMPLE_W` = 9, `COEF_W` = 16, `LANES` = 32)
  - the shift lookup by `N`
  - the size-code enum (`DCT4`, `DCT8`, `DCT16`, `DCT32`)
- One sub-module, `dct2_row_mac`, computes one output lane. Inputs are the row index k, `N`, and the sample vector. It does the multiply-accumulate, round, shift and clamp.
- The top level instantiates 32 `dct2_row_mac` copies and the output register.
- A butterfly (partial-butterfly) decomposition is an allowed substitute, provided results are bit-identical.

## Test plan
- Reset: hold `rst` = 1 with random input. `Y` = 0 every cycle. Deassert `rst`, apply a vector, and check it appears one cycle later.
- 4-point impulse: `N` = 0, x0 = 1, all other samples 0. Required: Y0 = 32, Y1 = 42, Y2 = 32, Y3 = 18, Y[511:64] = 0.
- 32-point DC: `N` = 3, all samples = 1. Required: Y0 = 128, all other lanes 0.
- 32-point negative extreme: `N` = 3, all samples = −256. Required: Y0 = −32768, others 0. Also all samples = 255: Y0 = 32640.
- Size masking: `N` = 1, samples 8..31 = random garbage, samples 0..7 = 0. Required: `Y` = 0. Repeat for `N` = 2.
- Random regression: 1000 random vectors with random `N`, compared against a software model of Operation. Include back-to-back `N` changes and a reset pulse mid-stream. Zero mismatches required.
